// File: rtl/alpha_scale.sv
// alpha_scale: rebuilds dark_diff = floor(alpha*denominator/2^ALPHA_W) with an MSB-first shift-add multiplier.
// Define ALPHA_SCALE_ROUND_EN for a round-half-up, saturated result instead of truncation.
module alpha_scale #(
  parameter int ALPHA_W = 7,
  parameter int DEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALPHA_W-1:0] alpha,
  input  logic [DEN_W-1:0]   denominator,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEN_W-1:0]   dark_diff
);

  // state | meaning
  // IDLE  | ready for a new alpha/denominator pair
  // BUSY  | one shift-add step per cycle, alpha bit cnt down to bit 0
  // DONE  | result held on dark_diff until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int ACC_W = ALPHA_W + DEN_W;
  localparam int CNT_W = (ALPHA_W > 1) ? $clog2(ALPHA_W) : 1;

  state_t             state, state_nxt;
  logic [ALPHA_W-1:0] alpha_q;
  logic [DEN_W-1:0]   den_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;
  logic [DEN_W-1:0]   result;

  assign last_step = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alpha_q <= '0;
      den_q   <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (state == IDLE && in_valid) begin
      alpha_q <= alpha;
      den_q   <= denominator;
      acc     <= '0;
      cnt     <= CNT_W'(ALPHA_W - 1);
    end else if (state == BUSY) begin
      acc <= {acc[ACC_W-2:0], 1'b0} + (alpha_q[cnt] ? ACC_W'(den_q) : '0);
      if (!last_step) cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef ALPHA_SCALE_ROUND_EN
  // One extra bit so the half-LSB add cannot wrap before saturation.
  logic [ACC_W:0] acc_rnd;
  logic [DEN_W:0] rnd_q;
  logic           unused_rnd_lsbs;

  assign acc_rnd         = {1'b0, acc} + ((ACC_W + 1)'(1) << (ALPHA_W - 1));
  assign rnd_q           = acc_rnd[ACC_W:ALPHA_W];
  assign result          = rnd_q[DEN_W] ? '1 : rnd_q[DEN_W-1:0];
  assign unused_rnd_lsbs = ^acc_rnd[ALPHA_W-1:0];
`else
  logic unused_acc_lsbs;

  assign result          = acc[ACC_W-1:ALPHA_W];
  assign unused_acc_lsbs = ^acc[ALPHA_W-1:0];
`endif

  assign dark_diff = out_valid ? result : '0;

endmodule
